// File: rtl/ab_pattern_gen_pkg.sv
// Shared definitions for the A/B pattern generator: FSM state encodings and
// the Gray pattern constants applied to the OR gate inputs.
package ab_pattern_gen_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam logic [1:0] PAT0 = 2'b00;
    localparam logic [1:0] PAT1 = 2'b01;
    localparam logic [1:0] PAT2 = 2'b11;
    localparam logic [1:0] PAT3 = 2'b10;

    function automatic logic [1:0] pat_of(input logic [1:0] ph);
        case (ph)
            2'd0:    return PAT0;
            2'd1:    return PAT1;
            2'd2:    return PAT2;
            default: return PAT3;
        endcase
    endfunction

endpackage

// File: rtl/ab_pattern_gen_hold_timer.sv
// Hold timer: counts enabled cycles 0..HOLD-1 and flags the terminal cycle.
// Shared by the board-level stimulus blocks.
module hold_timer #(
    parameter int unsigned HOLD = 10
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    input  logic clr,
    output logic tc
);

    localparam int unsigned CW = (HOLD > 1) ? $clog2(HOLD) : 1;
    localparam logic [CW-1:0] LAST = CW'(HOLD - 1);

    logic [CW-1:0] count;
    logic          at_last;

    assign at_last = (count == LAST);
    assign tc      = en && at_last;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (en) begin
            count <= at_last ? '0 : count + 1'b1;
        end
    end

endmodule

// File: rtl/ab_pattern_gen.sv
// A/B stimulus source for the two-input OR gate: steps the Gray sequence
// 00,01,11,10 with a programmable hold per pattern and a programmable pass count.
module ab_pattern_gen
    import ab_pattern_gen_pkg::*;
#(
    parameter int unsigned HOLD_CYCLES = 10,
    parameter int unsigned PASSES      = 10,
    parameter int unsigned PASS_W      = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              pause,
    output logic              a,
    output logic              b,
    output logic              step,
    output logic              busy,
    output logic              done,
    output logic [PASS_W-1:0] pass_idx,
    output state_t            fsm_state
);

    state_t            state, state_next;
    logic [1:0]        ph, ph_next;
    logic [PASS_W-1:0] pass_cnt, pass_next;
    logic              new_pat, new_pat_next;
    logic              run_first, last_pat, en, clr, tc;

    // The first RUN cycle always applies, so a start with pause high still
    // puts the first pattern on the gate.
    assign run_first = new_pat && (ph == 2'd0) && (pass_cnt == '0);
    assign last_pat  = (ph == 2'd3) && (pass_cnt == PASS_W'(PASSES - 1));
    assign en        = (state == ST_RUN) && (!pause || run_first);
    assign clr       = (state != ST_RUN);
    assign fsm_state = state;

    hold_timer #(.HOLD(HOLD_CYCLES)) u_hold (
        .clk (clk),
        .rst (rst),
        .en  (en),
        .clr (clr),
        .tc  (tc)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= ST_IDLE;
            ph       <= 2'd0;
            pass_cnt <= '0;
            new_pat  <= 1'b0;
        end else begin
            state    <= state_next;
            ph       <= ph_next;
            pass_cnt <= pass_next;
            new_pat  <= new_pat_next;
        end
    end

    always_comb begin
        state_next   = state;
        ph_next      = ph;
        pass_next    = pass_cnt;
        new_pat_next = new_pat;
        case (state)
            ST_IDLE: begin
                if (start) begin
                    state_next   = ST_RUN;
                    ph_next      = 2'd0;
                    pass_next    = '0;
                    new_pat_next = 1'b1;
                end
            end
            ST_RUN: begin
                new_pat_next = 1'b0;
                if (tc) begin
                    if (last_pat) begin
                        state_next = ST_DONE;
                    end else begin
                        ph_next      = ph + 2'd1;
                        new_pat_next = 1'b1;
                        if (ph == 2'd3) begin
                            pass_next = pass_cnt + 1'b1;
                        end
                    end
                end
            end
            ST_DONE: begin
                state_next = ST_IDLE;
                ph_next    = 2'd0;
                pass_next  = '0;
            end
            default: state_next = ST_IDLE;
        endcase
    end

    // Output stage: every output is a flop fed from the current internal state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a        <= 1'b0;
            b        <= 1'b0;
            step     <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
            pass_idx <= '0;
        end else begin
            {a, b}   <= (state == ST_RUN) ? pat_of(ph) : 2'b00;
            step     <= (state == ST_RUN) && new_pat;
            busy     <= (state == ST_RUN);
            done     <= (state == ST_DONE);
            pass_idx <= pass_cnt;
        end
    end

endmodule

// File: tb/tb_ab_pattern_gen.sv
// Bench for ab_pattern_gen: cycle-by-cycle comparison against a run-level
// reference model, plus directed scenarios and an edge-parameter instance.
module tb_ab_pattern_gen;
    import ab_pattern_gen_pkg::*;

    localparam int H  = 10;
    localparam int P  = 2;
    localparam int PW = 4;
    localparam int W  = 5 + PW;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic start = 1'b0;
    logic pause = 1'b0;
    logic start_e = 1'b0;

    logic a, b, step, busy, done;
    logic [PW-1:0] pass_idx;
    state_t fsm_state;

    logic a_e, b_e, step_e, busy_e, done_e;
    logic [0:0] pass_idx_e;
    state_t fsm_state_e;

    logic gate_y;
    assign gate_y = a | b;

    always #5 clk = ~clk;

    ab_pattern_gen #(.HOLD_CYCLES(H), .PASSES(P), .PASS_W(PW)) u_main (
        .clk(clk), .rst(rst), .start(start), .pause(pause),
        .a(a), .b(b), .step(step), .busy(busy), .done(done),
        .pass_idx(pass_idx), .fsm_state(fsm_state)
    );

    ab_pattern_gen #(.HOLD_CYCLES(1), .PASSES(1), .PASS_W(1)) u_edge (
        .clk(clk), .rst(rst), .start(start_e), .pause(1'b0),
        .a(a_e), .b(b_e), .step(step_e), .busy(busy_e), .done(done_e),
        .pass_idx(pass_idx_e), .fsm_state(fsm_state_e)
    );

    int n_cmp = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: a run is 4*P patterns, each consuming H unpaused cycles.
    logic [W-1:0] exp_q[$];
    bit m_run = 0, m_done = 0, m_fresh = 0, m_first = 0;
    int m_pos = 0, m_left = 0;

    function automatic logic [1:0] gray_ab(input int n);
        int k;
        k = n % 4;
        return 2'(k ^ (k >> 1));
    endfunction

    always @(posedge clk or posedge rst) begin : model_blk
        bit n_run, n_done, n_fresh, n_first;
        int n_pos, n_left;
        logic [1:0] e_ab;
        logic [PW-1:0] e_pass;
        if (rst) begin
            exp_q.delete();
            m_run <= 0; m_done <= 0; m_fresh <= 0; m_first <= 0;
            m_pos <= 0; m_left <= 0;
        end else begin
            e_ab   = m_run ? gray_ab(m_pos) : 2'b00;
            e_pass = m_done ? PW'(P - 1) : (m_run ? PW'(m_pos / 4) : '0);
            exp_q.push_back({m_run, m_run & m_fresh, m_done, e_ab, e_pass});
            n_run = m_run; n_done = m_done; n_fresh = m_fresh; n_first = m_first;
            n_pos = m_pos; n_left = m_left;
            if (m_done) begin
                n_done = 0;
            end else if (!m_run) begin
                if (start) begin
                    n_run = 1; n_pos = 0; n_left = H; n_fresh = 1; n_first = 1;
                end
            end else begin
                n_fresh = 0;
                n_first = 0;
                if (!pause || m_first) begin
                    n_left = m_left - 1;
                    if (n_left == 0) begin
                        n_pos = m_pos + 1;
                        if (n_pos == 4 * P) begin
                            n_run = 0; n_done = 1;
                        end else begin
                            n_left = H; n_fresh = 1;
                        end
                    end
                end
            end
            m_run <= n_run; m_done <= n_done; m_fresh <= n_fresh; m_first <= n_first;
            m_pos <= n_pos; m_left <= n_left;
        end
    end

    int cnt_busy = 0, cnt_step = 0, cnt_done = 0, cnt_p11 = 0;
    logic [1:0] prev_ab = 2'b00;
    logic prev_busy = 1'b0;

    always @(negedge clk) begin : chk_blk
        logic [W-1:0] e;
        if (!rst && exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check("busy", busy, e[W-1]);
            check("step", step, e[W-2]);
            check("done", done, e[W-3]);
            check("ab", {a, b}, e[PW+1:PW]);
            check("gate", gate_y, e[PW+1] | e[PW]);
            check("pass_idx", pass_idx, e[PW-1:0]);
            if (step) begin
                if (prev_busy) check("gray", $countones(prev_ab ^ {a, b}), 1);
                else           check("gray_first", {prev_ab, a, b}, 4'b0000);
            end
            cnt_busy  <= cnt_busy + int'(busy);
            cnt_step  <= cnt_step + int'(step);
            cnt_done  <= cnt_done + int'(done);
            cnt_p11   <= cnt_p11 + int'(busy && {a, b} == 2'b11 && pass_idx == '0);
            prev_ab   <= {a, b};
            prev_busy <= busy;
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick(1);
        start = 1'b0;
    endtask

    task automatic wait_done(input int budget, input string tag);
        bit ok;
        ok = 0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (done) begin
                ok = 1;
                break;
            end
        end
        check(tag, ok, 1);
        tick(1);
    endtask

    task automatic wait_ab(input logic [1:0] pat, input int budget, input string tag);
        bit ok;
        ok = 0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (busy && {a, b} == pat) begin
                ok = 1;
                break;
            end
        end
        check(tag, ok, 1);
        tick(1);
    endtask

    initial begin : watchdog
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin : main
        int b0, s0, d0, p0;
        logic [1:0] seq [4];
        seq = '{2'b00, 2'b01, 2'b11, 2'b10};

        // Reset state
        repeat (3) @(posedge clk);
        #2 rst = 1'b0;
        @(negedge clk);
        check("rst_ab", {a, b}, 2'b00);
        check("rst_flags", {step, busy, done}, 3'b000);
        check("rst_pass", pass_idx, 0);
        check("rst_state", fsm_state, ST_IDLE);
        tick(2);

        // Basic run
        b0 = cnt_busy; s0 = cnt_step; d0 = cnt_done;
        pulse_start();
        wait_done(300, "run1_timeout");
        tick(3);
        check("run1_busy", cnt_busy - b0, 80);
        check("run1_steps", cnt_step - s0, 8);
        check("run1_done", cnt_done - d0, 1);

        // Pause for 7 cycles mid pattern 11 of pass 0
        b0 = cnt_busy; p0 = cnt_p11;
        pulse_start();
        wait_ab(2'b11, 100, "pause_reach11");
        tick(2);
        s0 = cnt_step;
        pause = 1'b1;
        tick(7);
        pause = 1'b0;
        check("pause_no_step", cnt_step - s0, 0);
        wait_done(300, "pause_timeout");
        tick(3);
        check("pause_busy", cnt_busy - b0, 87);
        check("pause_hold11", cnt_p11 - p0, 17);

        // Start pulses while busy are ignored
        b0 = cnt_busy; d0 = cnt_done;
        pulse_start();
        tick(4);
        pulse_start();
        tick(34);
        pulse_start();
        wait_done(300, "ign_timeout");
        tick(5);
        check("ign_busy", cnt_busy - b0, 80);
        check("ign_done", cnt_done - d0, 1);

        // Asynchronous reset during pattern 01
        d0 = cnt_done;
        pulse_start();
        wait_ab(2'b01, 100, "rst_reach01");
        #1 rst = 1'b1;
        #1;
        check("arst_ab", {a, b}, 2'b00);
        check("arst_busy", busy, 0);
        check("arst_pass", pass_idx, 0);
        check("arst_state", fsm_state, ST_IDLE);
        #2 rst = 1'b0;
        tick(10);
        check("arst_no_done", cnt_done - d0, 0);
        b0 = cnt_busy; d0 = cnt_done;
        pulse_start();
        wait_done(300, "arst_run_timeout");
        tick(3);
        check("arst_run_busy", cnt_busy - b0, 80);
        check("arst_run_done", cnt_done - d0, 1);

        // Randomized start/pause traffic, checked cycle by cycle
        for (int r = 0; r < 3; r++) begin
            pulse_start();
            for (int c = 0; c < 300; c++) begin
                pause = ($urandom_range(0, 9) < 3);
                start = ($urandom_range(0, 19) == 0);
                tick(1);
            end
            start = 1'b0;
            pause = 1'b0;
            tick(100);
            check("rand_idle", busy, 0);
        end

        // HOLD_CYCLES=1, PASSES=1 instance
        start_e = 1'b1;
        tick(1);
        start_e = 1'b0;
        @(negedge clk);
        check("edge_pre", {busy_e, step_e, a_e, b_e}, 4'b0000);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("edge_ab", {a_e, b_e}, seq[i]);
            check("edge_step_busy", {step_e, busy_e, done_e}, 3'b110);
            check("edge_pass", pass_idx_e, 0);
        end
        @(negedge clk);
        check("edge_done", {done_e, busy_e, a_e, b_e}, 4'b1000);
        @(negedge clk);
        check("edge_idle", {done_e, busy_e}, 2'b00);
        check("edge_state", fsm_state_e, ST_IDLE);
        tick(2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
